// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default sizing for the uart_tx round-robin arbiter.
package uart_tx_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int START_TMO_DEF = 4;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    SEND      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid & unmasked index at or after ptr, with wrap.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand;

  // Explicit wrap compare keeps non-power-of-2 N correct.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && valid[cand] && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
      cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte requesters.
// Optional packet lock with macro UART_TX_ARB_LOCK_EN.
// state     | meaning
// ARB       | idle, accept one byte when uart is not busy
// ISSUE     | pulse tx_start with the registered byte
// WAIT_BUSY | wait for tx_busy to rise, bounded by START_TMO
// SEND      | frame in flight, wait for tx_busy to fall
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int START_TMO = START_TMO_DEF,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int TMO_W    = $clog2(START_TMO + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      grant_valid,
  output logic                      err_nostart
);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [TMO_W-1:0] tmo;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] mask;
  logic             accept;
  logic             tmo_done;
  logic             advance;
  logic [ID_W-1:0]  ptr_inc;

  rr_pick #(.N(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .mask  (mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef UART_TX_ARB_LOCK_EN
  logic            lock;
  logic [ID_W-1:0] lock_owner;

  always_comb begin
    mask = '1;
    if (lock) mask = {{(N_REQ-1){1'b0}}, 1'b1} << lock_owner;
  end

  // The round-robin pointer only moves once a packet completes.
  assign advance = req_last[pick_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      lock       <= 1'b0;
      lock_owner <= '0;
    end else if (accept) begin
      lock       <= !req_last[pick_idx];
      lock_owner <= pick_idx;
    end else if (tmo_done) begin
      lock       <= 1'b0;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign mask        = '1;
  assign advance     = 1'b1;
`endif

  assign ptr_inc = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_start  = 1'b0;
    accept    = 1'b0;
    tmo_done  = 1'b0;
    case (state)
      ARB: begin
        if (!tx_busy && pick_found) begin
          accept              = 1'b1;
          req_ready[pick_idx] = 1'b1;
          state_nxt           = ISSUE;
        end
      end
      ISSUE: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = SEND;
        end else if (tmo == TMO_W'(START_TMO - 1)) begin
          tmo_done  = 1'b1;
          state_nxt = ARB;
        end
      end
      SEND: begin
        if (!tx_busy) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      err_nostart <= 1'b0;
      rr_ptr      <= '0;
      tmo         <= '0;
    end else begin
      err_nostart <= tmo_done;
      if (accept) begin
        tx_data     <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
        if (advance) rr_ptr <= ptr_inc;
      end
      if (tmo_done || (state == SEND && !tx_busy)) grant_valid <= 1'b0;
      if (state == ISSUE) tmo <= '0;
      else if (state == WAIT_BUSY && !tx_busy) tmo <= tmo + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, randomized frames, timeout and reset sequences.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TMO  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          grant_valid;
  logic          err_nostart;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural uart: busy one cycle after tx_start, for frame_len cycles; ignores arbiter reset.
  int busy_cnt  = 0;
  int frame_len = 6;
  bit stuck     = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .START_TMO(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .err_nostart (err_nostart)
  );

  always @(posedge clk) begin
    if (tx_start && !stuck) busy_cnt <= frame_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  typedef struct {
    logic [3:0] valid;
    logic [7:0] base;
    int         exp_g;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((grant_valid || tx_busy) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", {31'd0, grant_valid | tx_busy}, 32'd0);
  endtask

  // One full frame from the current negedge; expects grant eg carrying byte ed.
  task automatic do_frame(input logic [3:0] v, input logic [31:0] d, input int eg,
                          input logic [7:0] ed);
    int t = 0;
    req_valid = v;
    req_data  = d;
    #1;
    while (req_ready == '0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("accept_ready", {28'd0, req_ready}, 32'd1 << eg);
    @(negedge clk);
    chk("issue_start", {31'd0, tx_start}, 32'd1);
    chk("issue_data", {24'd0, tx_data}, {24'd0, ed});
    chk("issue_gid", {30'd0, grant_id}, eg);
    chk("issue_gvalid", {31'd0, grant_valid}, 32'd1);
    chk("ready_one_cycle", {28'd0, req_ready}, 32'd0);
    req_valid = '0;
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ptr, g, cnt, bad;
    logic [3:0]  v;
    logic [31:0] d;

    tbl[0]  = '{4'b0001, 8'h10, 0, 8'h10};
    tbl[1]  = '{4'b0001, 8'h20, 0, 8'h20};
    tbl[2]  = '{4'b1111, 8'h30, 1, 8'h31};
    tbl[3]  = '{4'b1111, 8'h40, 2, 8'h42};
    tbl[4]  = '{4'b1111, 8'h50, 3, 8'h53};
    tbl[5]  = '{4'b1111, 8'h60, 0, 8'h60};
    tbl[6]  = '{4'b1001, 8'h70, 3, 8'h73};
    tbl[7]  = '{4'b0110, 8'h80, 1, 8'h81};
    tbl[8]  = '{4'b0011, 8'h90, 0, 8'h90};
    tbl[9]  = '{4'b1000, 8'hA0, 3, 8'hA3};
    tbl[10] = '{4'b0101, 8'hB0, 0, 8'hB0};
    tbl[11] = '{4'b0101, 8'hC0, 2, 8'hC2};

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_gvalid", {31'd0, grant_valid}, 32'd0);
    chk("rst_err", {31'd0, err_nostart}, 32'd0);

    for (int i = 0; i < 12; i++)
      do_frame(tbl[i].valid, mk_data(tbl[i].base), tbl[i].exp_g, tbl[i].exp_d);

    // Randomized frames against a plain round-robin model.
    do_reset();
    ptr = 0;
    for (int f = 0; f < 60; f++) begin
      v = 4'($urandom_range(1, 15));
      d = $urandom;
      frame_len = $urandom_range(2, 10);
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
      do_frame(v, d, g, d[g*8 +: 8]);
      ptr = (g + 1) % N;
    end

    // Stuck uart: start timeout, then re-arbitration from the advanced pointer.
    frame_len = 6;
    do_reset();
    stuck     = 1'b1;
    req_valid = 4'b0001;
    req_data  = mk_data(8'h55);
    #1;
    chk("stuck_accept", {28'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("stuck_issue", {31'd0, tx_start}, 32'd1);
    chk("stuck_data", {24'd0, tx_data}, 32'h55);
    req_valid = '0;
    cnt = 0;
    while (!err_nostart && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("tmo_cycles", cnt - 1, TMO);
    chk("tmo_gvalid", {31'd0, grant_valid}, 32'd0);
    stuck     = 1'b0;
    req_valid = 4'b0011;
    req_data  = mk_data(8'hE0);
    #1;
    chk("tmo_rearb", {28'd0, req_ready}, 32'b0010);
    @(negedge clk);
    chk("err_one_cycle", {31'd0, err_nostart}, 32'd0);
    chk("rearb_start", {31'd0, tx_start}, 32'd1);
    chk("rearb_gid", {30'd0, grant_id}, 32'd1);
    chk("rearb_data", {24'd0, tx_data}, 32'hE1);
    req_valid = '0;
    wait_idle();

    // Reset during SEND: outputs clear, pointer back to 0, no grant while uart still busy.
    frame_len = 12;
    do_reset();
    do_frame(4'b1000, mk_data(8'h00), 3, 8'h03);
    req_valid = 4'b0100;
    req_data  = mk_data(8'hD0);
    #1;
    chk("mid_accept", {28'd0, req_ready}, 32'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_send", {30'd0, grant_valid, tx_busy}, 32'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_gvalid", {31'd0, grant_valid}, 32'd0);
    chk("mid_rst_gid", {30'd0, grant_id}, 32'd0);
    chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = mk_data(8'hF0);
    #1;
    bad = 0;
    cnt = 0;
    while (tx_busy && cnt < 40) begin
      if (req_ready != '0) bad++;
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("no_grant_while_busy", bad, 0);
    chk("post_rst_ptr", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    chk("post_rst_data", {24'd0, tx_data}, 32'hF0);
    req_valid = '0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
